// File: rtl/shift_share_arbiter.sv
// rtl/shift_share_arbiter.sv - two-requester arbiter in front of one shared 32-bit shifter
// One operation in flight: IDLE accepts, EXEC captures the shifter result, RESP holds it.
module shift_share_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_fun,
  input  logic [4:0]  req0_shamt,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_fun,
  input  logic [4:0]  req1_shamt,
  input  logic [31:0] req1_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [31:0] sh_A,
  output logic [31:0] sh_B,
  output logic [1:0]  sh_fun,
  input  logic [31:0] sh_S,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        grant1;
  logic        accept;
  logic [1:0]  op_fun;
  logic [4:0]  op_shamt;
  logic [31:0] op_data;
  logic        op_id;

  // last_grant resets to 1 so that the first tie goes to req0
  always_comb begin
    grant1 = 1'b0;
    if (req1_valid) begin
      grant1 = !req0_valid || (!PRIO_FIXED && (last_grant == 1'b0));
    end
  end

  assign accept = (state == IDLE) && (req0_valid || req1_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ready is gated by reset so nothing looks accepted while reset is held
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (reset && (state == IDLE)) begin
      req0_ready = req0_valid && !grant1;
      req1_ready = grant1;
    end
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_fun     <= 2'b00;
      op_shamt   <= 5'd0;
      op_data    <= 32'd0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      rsp_result <= 32'd0;
      rsp_err    <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      if (accept) begin
        op_fun     <= grant1 ? req1_fun   : req0_fun;
        op_shamt   <= grant1 ? req1_shamt : req0_shamt;
        op_data    <= grant1 ? req1_data  : req0_data;
        op_id      <= grant1;
        last_grant <= grant1;
      end
      if (state == EXEC) begin
        rsp_result <= (op_fun == 2'b10) ? 32'd0 : sh_S;
        rsp_err    <= (op_fun == 2'b10);
        rsp_id     <= op_id;
      end
    end
  end

  // shifter inputs come straight from registers so they never glitch
  assign sh_A   = {27'd0, op_shamt};
  assign sh_B   = op_data;
  assign sh_fun = op_fun;

endmodule
